lsu_wb: RTL and testbench

- Load/store and write-back stage placed after the execute stage.
- Accepts one retired-instruction record from EX: ALU result/address, store data, destination register and control bits.
- Performs any data-memory access over a req/ack handshake to a multi-cycle memory.
- Drives the register-file write port (write data, destination, write enable) that the decode stage's register file consumes; it is the writer side of that port.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu_wb.sv | 174 +++++++++++++++++
 tb/tb_lsu_wb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store + write-back stage:
// access-size encodings, FSM state type and datapath width.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WB
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Store side: byte enables, replicated write data and misalignment flag.
// Load side: byte/halfword selection with sign or zero extension.
// Undefined access sizes behave as full-word accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_offset,
    input  logic [DATA_W-1:0] st_data,
    output logic [3:0]        st_be,
    output logic [DATA_W-1:0] st_wdata,
    output logic              misalign,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_offset,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store lane enables, lane-replicated data and alignment check
    always_comb begin
        st_be    = '1;
        st_wdata = st_data;
        misalign = 1'b0;
        case (st_funct3)
            F3_B, F3_BU: begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
                misalign = st_offset[0];
            end
            default: misalign = (st_offset != 2'b00);
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        case (ld_offset)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'b0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'b0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Load/store and write-back stage following execute.
// Accepts one record from EX, performs an optional memory access over a
// req/ack handshake and drives the register-file write port.
// Optional: define LSU_TIMEOUT_EN to abort requests unacknowledged for
// TIMEOUT_CYCLES cycles (reported as err with no register write).
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_z,
    input  logic [DATA_W-1:0] ex_rd2,
    input  logic [4:0]        ex_rd,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    state_t state, state_nxt;

    logic              accept;
    logic              is_mem;
    logic              misalign;
    logic              bad_access;
    logic              timeout;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_data;

    logic [4:0]        rd_q;
    logic              we_q;
    logic              err_q;
    logic              load_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] data_q;

    assign accept     = ex_valid && (state == IDLE);
    assign is_mem     = ex_mem_read || ex_mem_write;
    assign bad_access = is_mem && misalign;

    lsu_align u_align (
        .st_funct3 (ex_funct3),
        .st_offset (ex_z[1:0]),
        .st_data   (ex_rd2),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .misalign  (misalign),
        .ld_funct3 (f3_q),
        .ld_offset (off_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    // Count cycles spent waiting in REQ; restarts with each accepted record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (accept)         cnt <= '0;
        else if (state == REQ)   cnt <= cnt + 1'b1;
    end

    // An ack on the last counted cycle takes priority over the abort
    assign timeout = (state == REQ) && !mem_ack &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        ex_ready  = 1'b0;
        mem_req   = 1'b0;
        wb_valid  = 1'b0;
        case (state)
            IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid) state_nxt = (is_mem && !misalign) ? REQ : WB;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack || timeout) state_nxt = WB;
            end
            WB: begin
                wb_valid  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Record capture at accept; load data / abort status captured in REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            data_q   <= '0;
        end else if (accept) begin
            rd_q     <= ex_rd;
            we_q     <= ex_reg_write && (ex_rd != 5'd0) && !bad_access;
            err_q    <= bad_access;
            load_q   <= ex_mem_read;
            f3_q     <= ex_funct3;
            off_q    <= ex_z[1:0];
            mem_we_q <= ex_mem_write && !ex_mem_read;
            addr_q   <= {ex_z[DATA_W-1:2], 2'b00};
            wdata_q  <= ex_mem_read ? '0 : st_wdata;
            be_q     <= ex_mem_read ? 4'b1111 : st_be;
            data_q   <= ex_z;
        end else if (state == REQ) begin
            if (mem_ack) begin
                if (load_q) data_q <= ld_data;
            end else if (timeout) begin
                we_q  <= 1'b0;
                err_q <= 1'b1;
            end
        end
    end

    // Memory and write-back buses read zero outside their active state
    assign mem_we    = mem_req && mem_we_q;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_be    = mem_req ? be_q    : '0;
    assign wb_we     = wb_valid && we_q;
    assign wb_rd     = wb_valid ? rd_q   : '0;
    assign wb_data   = wb_valid ? data_q : '0;
    assign err       = wb_valid && err_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: a table of single-record vectors with a
// write-back scoreboard, plus hand sequences for reset, stray acks and
// the request timeout (both with and without LSU_TIMEOUT_EN).
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_z;
    logic [31:0] ex_rd2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    always #5 clk = ~clk;

    lsu_wb #(.DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_z         (ex_z),
        .ex_rd2       (ex_rd2),
        .ex_rd        (ex_rd),
        .ex_funct3    (ex_funct3),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_reg_write (ex_reg_write),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .err          (err)
    );

    typedef struct {
        logic [31:0] z;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic        rw;
        int          dly;      // REQ cycles before ack (0: no request expected)
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } wb_t;

    vec_t vecs[$];
    wb_t  sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] z, input logic [31:0] rd2,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic mr, input logic mw, input logic rw,
                                input int dly, input logic [31:0] rdata,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd, input logic we,
                                input logic [31:0] data, input logic e);
        vec_t v;
        v.z = z; v.rd2 = rd2; v.rd = rd; v.f3 = f3;
        v.mr = mr; v.mw = mw; v.rw = rw; v.dly = dly; v.rdata = rdata;
        v.exp_addr = addr; v.exp_be = be; v.exp_wdata = wd;
        v.exp_we = we; v.exp_data = data; v.exp_err = e;
        return v;
    endfunction

    task automatic drive_rec(input logic [31:0] z, input logic [31:0] rd2, input logic [4:0] rd,
                             input logic [2:0] f3, input logic mr, input logic mw, input logic rw);
        ex_valid     = 1'b1;
        ex_z         = z;
        ex_rd2       = rd2;
        ex_rd        = rd;
        ex_funct3    = f3;
        ex_mem_read  = mr;
        ex_mem_write = mw;
        ex_reg_write = rw;
        @(posedge clk);
        #1;
        ex_valid     = 1'b0;
        ex_z         = $urandom;
        ex_rd2       = $urandom;
        ex_rd        = 5'($urandom);
        ex_funct3    = 3'($urandom);
        ex_mem_read  = 1'($urandom);
        ex_mem_write = 1'($urandom);
        ex_reg_write = 1'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  req_cyc = 0;
        int  busy    = 0;
        bit  done    = 0;
        wb_t e;
        @(negedge clk);
        check($sformatf("v%0d_ready_idle", idx), 32'(ex_ready), 32'd1);
        e.we = v.exp_we; e.rd = v.rd; e.data = v.exp_data; e.err = v.exp_err;
        sb_q.push_back(e);
        drive_rec(v.z, v.rd2, v.rd, v.f3, v.mr, v.mw, v.rw);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!ex_ready) busy++;
            if (mem_req) begin
                req_cyc++;
                check($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
                check($sformatf("v%0d_mem_be", idx), 32'(mem_be), 32'(v.exp_be));
                check($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.mw && !v.mr));
                if (v.mw && !v.mr)
                    check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
                if (req_cyc == v.dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (wb_valid) begin
                done = 1;
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_unexpected_wb", idx), 32'(wb_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("v%0d_wb_we", idx), 32'(wb_we), 32'(e.we));
                    check($sformatf("v%0d_err", idx), 32'(err), 32'(e.err));
                    if (e.we) begin
                        check($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), 32'(e.rd));
                        check($sformatf("v%0d_wb_data", idx), wb_data, e.data);
                    end
                end
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
        check($sformatf("v%0d_wb_seen", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_req_cycles", idx), 32'(req_cyc), 32'(v.dly));
        check($sformatf("v%0d_busy_cycles", idx), 32'(busy), 32'(v.dly + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  hi;
        int  req;
        bit  seen;

        //            z             rd2           rd  f3      mr mw rw dly rdata         addr          be       wdata         we data          err
        vecs.push_back(mk(32'h0000_1234, 32'h0,        5,  3'b000, 0, 0, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 32'h0000_1234, 0));
        vecs.push_back(mk(32'h0000_0103, 32'hAABBCCDD, 0,  3'b000, 0, 1, 0, 3, 32'h0,        32'h0000_0100, 4'b1000, 32'hDDDDDDDD, 0, 32'h0,        0));
        vecs.push_back(mk(32'h0000_0101, 32'h0,        7,  3'b000, 1, 0, 1, 1, 32'h0000_8000, 32'h0000_0100, 4'b1111, 32'h0,        1, 32'hFFFF_FF80, 0));
        vecs.push_back(mk(32'h0000_0101, 32'h0,        7,  3'b100, 1, 0, 1, 1, 32'h0000_8000, 32'h0000_0100, 4'b1111, 32'h0,        1, 32'h0000_0080, 0));
        vecs.push_back(mk(32'h0000_0102, 32'h0,        3,  3'b010, 1, 0, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 32'h0,        1));
        vecs.push_back(mk(32'h0000_0102, 32'h0,        0,  3'b001, 1, 0, 1, 2, 32'h1234_5678, 32'h0000_0100, 4'b1111, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(32'h0000_0102, 32'h0,        9,  3'b001, 1, 0, 1, 1, 32'h8765_4321, 32'h0000_0100, 4'b1111, 32'h0,        1, 32'hFFFF_8765, 0));
        vecs.push_back(mk(32'h0000_0100, 32'h0,        10, 3'b101, 1, 0, 1, 1, 32'h8765_F321, 32'h0000_0100, 4'b1111, 32'h0,        1, 32'h0000_F321, 0));
        vecs.push_back(mk(32'h0000_0202, 32'h11223344, 0,  3'b001, 0, 1, 0, 2, 32'h0,        32'h0000_0200, 4'b1100, 32'h33443344, 0, 32'h0,        0));
        vecs.push_back(mk(32'h0000_0300, 32'hCAFEBABE, 0,  3'b010, 0, 1, 0, 1, 32'h0,        32'h0000_0300, 4'b1111, 32'hCAFEBABE, 0, 32'h0,        0));
        vecs.push_back(mk(32'h0000_0404, 32'h0,        31, 3'b010, 1, 0, 1, 1, 32'hDEADBEEF, 32'h0000_0404, 4'b1111, 32'h0,        1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(32'h0000_0201, 32'h0000FFFF, 0,  3'b001, 0, 1, 0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 32'h0,        1));
        vecs.push_back(mk(32'h0000_0055, 32'h0,        0,  3'b000, 0, 0, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(32'h0000_0010, 32'h12345678, 4,  3'b010, 1, 1, 1, 1, 32'h0000_0055, 32'h0000_0010, 4'b1111, 32'h0,        1, 32'h0000_0055, 0));
        vecs.push_back(mk(32'h0000_0020, 32'h0,        6,  3'b011, 1, 0, 1, 1, 32'h1234_ABCD, 32'h0000_0020, 4'b1111, 32'h0,        1, 32'h1234_ABCD, 0));
        vecs.push_back(mk(32'h0000_0022, 32'h0,        6,  3'b011, 1, 0, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 32'h0,        1));
        vecs.push_back(mk(32'h0000_0501, 32'h000000EE, 0,  3'b000, 0, 1, 0, 2, 32'h0,        32'h0000_0500, 4'b0010, 32'hEEEEEEEE, 0, 32'h0,        0));
        vecs.push_back(mk(32'h0000_0102, 32'h0,        8,  3'b000, 1, 0, 1, 3, 32'h007F_0000, 32'h0000_0100, 4'b1111, 32'h0,        1, 32'h0000_007F, 0));
        vecs.push_back(mk(32'hFFFF_0001, 32'h0,        1,  3'b010, 0, 0, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 32'hFFFF_0001, 0));
        vecs.push_back(mk(32'h0000_0100, 32'h0,        2,  3'b001, 1, 0, 1, 2, 32'h0000_FFFE, 32'h0000_0100, 4'b1111, 32'h0,        1, 32'hFFFF_FFFE, 0));

        rst_n        = 1'b0;
        ex_valid     = 1'b0;
        ex_z         = '0;
        ex_rd2       = '0;
        ex_rd        = '0;
        ex_funct3    = '0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_reg_write = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Stray acks while idle must not start or retire anything
        @(negedge clk);
        mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stray_ack_wb_valid", 32'(wb_valid), 32'd0);
            check("stray_ack_mem_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;

        // Reset in the middle of an access
        @(negedge clk);
        drive_rec(32'h0000_0600, 32'h01020304, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("midrst_req_before", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_req_dropped", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_no_wb", 32'(wb_valid), 32'd0);
            check("midrst_ready", 32'(ex_ready), 32'd1);
            check("midrst_no_req", 32'(mem_req), 32'd0);
        end

`ifdef LSU_TIMEOUT_EN
        // Unanswered request aborts after four cycles
        @(negedge clk);
        drive_rec(32'h0000_0700, 32'h0, 5'd12, 3'b010, 1'b1, 1'b0, 1'b1);
        req  = 0;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) req++;
            if (wb_valid) begin
                seen = 1;
                check("to_err", 32'(err), 32'd1);
                check("to_wb_we", 32'(wb_we), 32'd0);
            end
        end
        check("to_wb_seen", 32'(seen), 32'd1);
        check("to_req_cycles", 32'(req), 32'd4);
        // Ack on the final counted cycle completes normally
        run_vec(mk(32'h0000_0704, 32'h0, 13, 3'b010, 1, 0, 1, 4, 32'hA5A5_A5A5,
                   32'h0000_0704, 4'b1111, 32'h0, 1, 32'hA5A5_A5A5, 0), 100);
`else
        // Without the timeout the request is held indefinitely
        @(negedge clk);
        drive_rec(32'h0000_0700, 32'h0, 5'd12, 3'b010, 1'b1, 1'b0, 1'b1);
        hi = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (mem_req && !wb_valid) hi++;
        end
        check("noto_req_held", 32'(hi), 32'd120);
        #1 rst_n = 1'b0;
        #1;
        check("noto_rst_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("noto_ready", 32'(ex_ready), 32'd1);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
